// File: rtl/conv_seq_pkg.sv
// Shared types and sizing helpers for the convolution layer sequencer.
// LOG2 gives the bit width needed to hold values 0..x-1 (minimum 1).
`ifndef LOG2
`define LOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

package conv_seq_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  function automatic int out_size(input int image_size, input int filter_size, input int stride);
    return (image_size - filter_size) / stride + 1;
  endfunction

endpackage

// File: rtl/seq_out_fifo.sv
// Two-entry result FIFO; head is visible combinationally, push and pop may share a cycle.
// A push into a full FIFO without a simultaneous pop is dropped; the sequencer's credit rule prevents it.
module seq_out_fifo #(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         head_valid,
  output logic [W-1:0] head_data,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_pop     = pop && (count != 2'd0);
  assign do_push    = push && ((count != 2'd2) || do_pop);
  assign head_valid = (count != 2'd0);
  assign head_data  = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

  // Payload storage needs no reset: it is only observed while count != 0.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/conv_layer_sequencer.sv
// Sequences one conv layer per frame: gates clk_en per accepted pixel, captures windows into a 2-deep FIFO.
// Result appears one cycle after its pixel is accepted; in_ready drops whenever the FIFO could not absorb another result.
module conv_layer_sequencer
  import conv_seq_pkg::*;
#(
  parameter int IMAGE_SIZE   = 8,
  parameter int FILTER_SIZE  = 3,
  parameter int STRIDE       = 1,
  parameter int O_WIDTH      = 16,
  parameter int CHANNELS_OUT = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic                            layer_clk_en,
  input  logic                            layer_valid,
  input  logic [O_WIDTH*CHANNELS_OUT-1:0] layer_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [O_WIDTH*CHANNELS_OUT-1:0] out_data,
  output logic                            out_last,
  output logic                            busy,
  output logic                            done,
  output logic                            count_err
);

  localparam int DW       = O_WIDTH * CHANNELS_OUT;
  localparam int OUT_SIZE = out_size(IMAGE_SIZE, FILTER_SIZE, STRIDE);
  localparam int N_OUT    = OUT_SIZE * OUT_SIZE;
  localparam int CW       = `LOG2(N_OUT + 1);
  localparam int PW       = `LOG2(IMAGE_SIZE);

  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [CW-1:0] CNT_N     = CW'(N_OUT);
  localparam logic [CW-1:0] CNT_LAST  = CW'(N_OUT - 1);
  localparam logic [PW-1:0] POS_LAST  = PW'(IMAGE_SIZE - 1);

  state_t        state;
  logic [PW-1:0] row;
  logic [PW-1:0] col;
  logic          en_d;
  logic [CW-1:0] out_cnt;
  logic [1:0]    fifo_count;
  logic          push;
  logic          pop;
  logic [2:0]    credit;
  logic [DW:0]   head;

  // Slots already committed: stored entries plus a result still in flight, minus the one leaving now.
  assign pop          = out_valid && out_ready;
  assign push         = en_d && layer_valid;
  assign credit       = {1'b0, fifo_count} + {2'b00, en_d} - {2'b00, pop};
  assign in_ready     = (state == RUN) && (credit < 3'd2);
  assign layer_clk_en = in_valid && in_ready;
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);
  assign out_data     = head[DW-1:0];
  assign out_last     = out_valid && head[DW];

  seq_out_fifo #(.W(DW + 1)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({out_cnt == CNT_LAST, layer_data}),
    .pop       (pop),
    .head_valid(out_valid),
    .head_data (head),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      en_d      <= 1'b0;
      out_cnt   <= '0;
      count_err <= 1'b0;
    end else begin
      en_d <= layer_clk_en;
      if (push && out_cnt != CNT_MAX) out_cnt <= out_cnt + 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            row       <= '0;
            col       <= '0;
            out_cnt   <= '0;
            count_err <= 1'b0;
          end
        end
        RUN: begin
          if (layer_clk_en) begin
            if (col == POS_LAST) begin
              col <= '0;
              if (row == POS_LAST) state <= FLUSH;
              else                 row   <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        FLUSH: begin
          if (!en_d && fifo_count == 2'd0) begin
            state     <= DONE;
            count_err <= count_err | (out_cnt != CNT_N);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Directed bench: table of frame scenarios on a stride-1 instance, plus stride-2 and mid-frame reset sequences.
module tb_conv_layer_sequencer;
  import conv_seq_pkg::*;

  localparam int IMG = 8;
  localparam int DW  = 64;
  localparam int N1  = 36;
  localparam int N2  = 9;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          start, in_valid, in_ready, layer_clk_en, layer_valid;
  logic [DW-1:0] layer_data, out_data;
  logic          out_valid, out_ready, out_last, busy, done, count_err;

  logic          start2, in_valid2, in_ready2, layer_clk_en2, layer_valid2;
  logic [DW-1:0] layer_data2, out_data2;
  logic          out_valid2, out_ready2, out_last2, busy2, done2, count_err2;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  conv_layer_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .layer_clk_en(layer_clk_en), .layer_valid(layer_valid), .layer_data(layer_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .count_err(count_err)
  );

  conv_layer_sequencer #(.STRIDE(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .in_valid(in_valid2), .in_ready(in_ready2),
    .layer_clk_en(layer_clk_en2), .layer_valid(layer_valid2), .layer_data(layer_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .out_last(out_last2),
    .busy(busy2), .done(done2), .count_err(count_err2)
  );

  function automatic bit is_win(input int p, input int s);
    int r, c;
    r = p / IMG;
    c = p % IMG;
    return (r >= 2) && (c >= 2) && ((r - 2) % s == 0) && ((c - 2) % s == 0);
  endfunction

  function automatic logic [DW-1:0] data_of(input int p);
    return {16'hC0DE, 8'(p / IMG), 8'(p % IMG), 16'(p), 16'h5A5A};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Layer stubs: a window result follows the accepted pixel by one edge and holds until the next accept.
  int pix1, win1, suppress;
  bit junk, stub_clr;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pix1 <= 0; win1 <= 0; layer_valid <= 1'b0; layer_data <= '0;
    end else if (stub_clr) begin
      pix1 <= 0; win1 <= 0; layer_valid <= 1'b0;
    end else if (layer_clk_en) begin
      pix1 <= pix1 + 1;
      if (is_win(pix1, 1)) begin
        win1        <= win1 + 1;
        layer_valid <= (win1 != suppress);
        layer_data  <= data_of(pix1);
      end else begin
        layer_valid <= 1'b0;
      end
    end else if (junk) begin
      layer_valid <= 1'b1;
      layer_data  <= 64'hDEAD_BEEF_DEAD_BEEF;
    end
  end

  int pix2;
  bit stub_clr2;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pix2 <= 0; layer_valid2 <= 1'b0; layer_data2 <= '0;
    end else if (stub_clr2) begin
      pix2 <= 0; layer_valid2 <= 1'b0;
    end else if (layer_clk_en2) begin
      pix2         <= pix2 + 1;
      layer_valid2 <= is_win(pix2, 2);
      layer_data2  <= data_of(pix2);
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0 && dut.push && dut.fifo_count == 2'd2 && !dut.pop) begin
      errors++;
      $display("FAIL fifo_overflow: push into full FIFO at cycle %0d", cyc);
    end
    if (rst === 1'b0 && dut2.push && dut2.fifo_count == 2'd2 && !dut2.pop) begin
      errors++;
      $display("FAIL fifo_overflow2: push into full FIFO at cycle %0d", cyc);
    end
  end

  // vmode: 0 in_valid held high, 1 toggling. rmode: 0 ready high, 1 random, 2 stall 20 cycles after first output.
  typedef struct {
    int vmode;
    int rmode;
    int sup;
    bit junk;
    bit smid;
    bit span;
    int exp_n;
    bit exp_err;
  } vec_t;

  vec_t vecs[5];

  task automatic run_frame(input vec_t v, input string tag);
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_d[$];
    bit            got_l[$];
    int idx = 0, en_n = 0, en_first = -1, en_last = -1, done_n = 0, done_cyc = -1;
    int last_pop = -1, pops = 0, stall = 0, post = 0, nbad = 0, lbad = 0;
    bit stall_chk = 0;
    for (int p = 0; p < IMG * IMG; p++) begin
      if (is_win(p, 1)) begin
        if (idx != v.sup) exp_q.push_back(data_of(p));
        idx++;
      end
    end
    suppress = v.sup;
    junk     = v.junk;
    @(posedge clk); #1;
    start = 1'b1; stub_clr = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stub_clr = 1'b0;
    for (int i = 0; i < 3000 && post < 4; i++) begin
      in_valid = (v.vmode == 0) ? 1'b1 : (i % 2 == 0);
      start    = v.smid && (i == 10);
      if (v.rmode == 1) out_ready = 1'($urandom_range(0, 1));
      else if (v.rmode == 2 && pops >= 1 && stall < 20) begin
        out_ready = 1'b0;
        stall++;
      end else out_ready = 1'b1;
      @(negedge clk);
      if (i == 0) begin
        check({tag, "_start_clears_err"}, count_err, 1'b0);
        check({tag, "_busy"}, busy, 1'b1);
      end
      if (v.rmode == 2 && stall == 20 && !stall_chk) begin
        stall_chk = 1;
        check({tag, "_stall_fifo_full"}, dut.fifo_count, 2'd2);
        check({tag, "_stall_in_ready"}, in_ready, 1'b0);
        check({tag, "_stall_clk_en"}, layer_clk_en, 1'b0);
      end
      if (layer_clk_en) begin
        en_n++;
        if (en_first < 0) en_first = cyc;
        en_last = cyc;
      end
      if (out_valid && out_ready) begin
        got_d.push_back(out_data);
        got_l.push_back(out_last);
        pops++;
        last_pop = cyc;
      end
      if (done) begin
        done_n++;
        done_cyc = cyc;
      end
      if (done_n > 0) post++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    check({tag, "_done_pulses"}, done_n, 1);
    check({tag, "_clk_en_count"}, en_n, IMG * IMG);
    check({tag, "_out_count"}, got_d.size(), v.exp_n);
    for (int k = 0; k < got_d.size(); k++) begin
      if (k >= exp_q.size() || got_d[k] !== exp_q[k]) nbad++;
      if (got_l[k] !== (k == N1 - 1)) lbad++;
    end
    check({tag, "_data_seq_bad"}, nbad, 0);
    check({tag, "_last_flag_bad"}, lbad, 0);
    check({tag, "_count_err_held"}, count_err, v.exp_err);
    if (v.span) begin
      check({tag, "_clk_en_span"}, en_last - en_first + 1, IMG * IMG);
      check({tag, "_done_after_drain"}, done_cyc, last_pop + 2);
    end
  endtask

  initial begin
    int en_n, got;
    bit done_seen, last_ok;
    vecs[0] = '{vmode: 0, rmode: 0, sup: -1, junk: 0, smid: 0, span: 1, exp_n: 36, exp_err: 0};
    vecs[1] = '{vmode: 0, rmode: 2, sup: -1, junk: 0, smid: 1, span: 0, exp_n: 36, exp_err: 0};
    vecs[2] = '{vmode: 1, rmode: 1, sup: -1, junk: 1, smid: 0, span: 0, exp_n: 36, exp_err: 0};
    vecs[3] = '{vmode: 0, rmode: 0, sup: 10, junk: 0, smid: 0, span: 0, exp_n: 35, exp_err: 1};
    vecs[4] = '{vmode: 1, rmode: 0, sup: -1, junk: 1, smid: 0, span: 0, exp_n: 36, exp_err: 0};

    rst = 1'b1; start = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    start2 = 1'b0; in_valid2 = 1'b1; out_ready2 = 1'b1;
    suppress = -1; junk = 1'b0; stub_clr = 1'b0; stub_clr2 = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_clk_en", layer_clk_en, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_count_err", count_err, 1'b0);
    check("rst_busy2", busy2, 1'b0);
    @(posedge clk); #1 rst = 1'b0;

    for (int v = 0; v < 5; v++) run_frame(vecs[v], $sformatf("v%0d", v));

    // Stride-2 instance: nine outputs, last flag on the ninth.
    @(posedge clk); #1 start2 = 1'b1; stub_clr2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0; stub_clr2 = 1'b0;
    got = 0; done_seen = 0; last_ok = 1;
    for (int i = 0; i < 500 && !done_seen; i++) begin
      @(negedge clk);
      if (out_valid2 && out_ready2) begin
        if (got < N2) check($sformatf("s2_data%0d", got), out_data2,
                            data_of((2 + 2 * (got / 3)) * IMG + 2 + 2 * (got % 3)));
        if (out_last2 !== (got == N2 - 1)) last_ok = 0;
        got++;
      end
      if (done2) done_seen = 1;
      @(posedge clk); #1;
    end
    check("s2_done", done_seen, 1'b1);
    check("s2_out_count", got, N2);
    check("s2_last_ok", last_ok, 1'b1);
    check("s2_count_err", count_err2, 1'b0);

    // Reset in the middle of a frame, right after pixel 30 is accepted.
    @(posedge clk); #1 start = 1'b1; stub_clr = 1'b1; suppress = -1; junk = 1'b0;
    @(posedge clk); #1 start = 1'b0; stub_clr = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    en_n = 0;
    for (int i = 0; i < 200 && en_n < 30; i++) begin
      @(negedge clk);
      if (layer_clk_en) en_n++;
      @(posedge clk); #1;
    end
    check("mid_reached_30", en_n, 30);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_in_ready", in_ready, 1'b0);
    check("mid_rst_clk_en", layer_clk_en, 1'b0);
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_out_last", out_last, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_count_err", count_err, 1'b0);
    check("mid_rst_state", dut.state, IDLE);
    check("mid_rst_fifo", dut.fifo_count, 2'd0);
    done_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) done_seen = 1;
    end
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) done_seen = 1;
    end
    check("mid_rst_no_done", done_seen, 1'b0);
    run_frame(vecs[0], "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
